rm_ihpsg13_bist_march_ctrl: RTL and testbench

//  March C- BIST controller for the 1-port SRAM macros with BIST port (sized for the 256x64 c2_bm variant).

---
 rtl/rm_bist_pkg.sv | 21 ++
 rtl/rm_bist_cmp.sv | 46 ++++
 rtl/rm_ihpsg13_bist_march_ctrl.sv | 98 +++++++++
 tb/tb_rm_ihpsg13_bist_march_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rm_bist_pkg.sv
// rm_bist_pkg: March C- element table and FSM state for the SRAM BIST controller
package rm_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic down;
    logic two;
    logic wr0;
    logic inv0;
    logic inv1;
  } elem_t;
  localparam logic [2:0] LAST_ELEM = 3'd5;
  // One bit per element E5..E0: direction, two-op element, slot-0 write, slot-0/slot-1 data inverted
  localparam logic [5:0] DOWN = 6'b111000;
  localparam logic [5:0] TWO  = 6'b011110;
  localparam logic [5:0] WR0  = 6'b000001;
  localparam logic [5:0] INV0 = 6'b010100;
  localparam logic [5:0] INV1 = 6'b001010;
  function automatic elem_t march(input logic [2:0] e);
    return '{DOWN[e], TWO[e], WR0[e], INV0[e], INV1[e]};
  endfunction
endpackage

// File: rtl/rm_bist_cmp.sv
// rm_bist_cmp: registered expected-data pipeline, mismatch detect and first-fail capture
module rm_bist_cmp #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] exp_data,
  input  logic [2:0]    elem,
  input  logic [DW-1:0] dout,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_xor,
  output logic [2:0]    fail_elem
);
  logic          v;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_exp;
  logic [2:0]    q_elem;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      v <= 1'b0;
      q_addr <= '0;
      q_exp <= '0;
      q_elem <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_xor <= '0;
      fail_elem <= '0;
    end else begin
      v <= rd;
      q_addr <= addr;
      q_exp <= exp_data;
      q_elem <= elem;
      if (v && dout != q_exp && !fail) begin
        fail <= 1'b1;
        fail_addr <= q_addr;
        fail_xor <= dout ^ q_exp;
        fail_elem <= q_elem;
      end
    end
  end
endmodule

// File: rtl/rm_ihpsg13_bist_march_ctrl.sv
// rm_ihpsg13_bist_march_ctrl: March C- BIST controller driving the SRAM macro BIST port
module rm_ihpsg13_bist_march_ctrl
  import rm_bist_pkg::*;
#(
  parameter int                      P_ADDR_WIDTH = 8,
  parameter int                      P_DATA_WIDTH = 64,
  parameter int                      P_NUM_BG     = 2,
  parameter logic [P_DATA_WIDTH-1:0] P_BG1        = {32{2'b01}}
) (
  input  logic                    BIST_CLK,
  input  logic                    BIST_RESET_N,
  input  logic                    BIST_START,
  input  logic                    BIST_ABORT,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  output logic                    BIST_BUSY,
  output logic                    BIST_DONE,
  output logic                    BIST_FAIL,
  output logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_FAIL_XOR,
  output logic [2:0]              BIST_FAIL_ELEM
);
  state_t                  st, st_n;
  elem_t                   el;
  logic [P_ADDR_WIDTH-1:0] addr, addr_n;
  logic [P_DATA_WIDTH-1:0] bgd, data, exp_d;
  logic [2:0]              elem, elem_n, op_elem;
  logic                    bg, slot, fin, go, stop, issue, last_slot, elem_end, last, wr, inv;
  always_comb begin
    el = march(elem);
    last_slot = !el.two || slot;
    elem_end = last_slot && (el.down ? addr == '0 : addr == '1);
    elem_n = elem == LAST_ELEM ? 3'd0 : elem + 3'd1;
    last = elem_end && elem == LAST_ELEM && bg == 1'(P_NUM_BG - 1);
    wr = slot || el.wr0;
    inv = slot ? el.inv1 : el.inv0;
    bgd = bg ? P_BG1 : '0;
    data = inv ? ~bgd : bgd;
    addr_n = !last_slot ? addr : elem_end ? {P_ADDR_WIDTH{DOWN[elem_n]}} : el.down ? addr - 1'b1 : addr + 1'b1;
    go = BIST_START && !BIST_ABORT && (st == IDLE || st == DONE);
    stop = BIST_ABORT && (st == RUN || st == DRAIN);
    issue = go || (st == RUN && !fin && !BIST_ABORT);
    st_n = stop ? IDLE : go ? RUN : (st == RUN && fin) ? DRAIN : st == DRAIN ? DONE : st;
  end
  // The op pointer (bg/elem/addr/slot) sits at zero whenever no op is being issued,
  // so a START always begins at E0, address 0, background 0.
  always_ff @(posedge BIST_CLK) begin
    if (!BIST_RESET_N) begin
      st <= IDLE;
      {A_BIST_EN, BIST_BUSY, BIST_DONE} <= '0;
      {A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN} <= '0;
      {bg, elem, addr, slot, fin, exp_d, op_elem} <= '0;
    end else begin
      st <= st_n;
      A_BIST_EN <= st_n == RUN || st_n == DRAIN;
      BIST_BUSY <= st_n == RUN || st_n == DRAIN;
      BIST_DONE <= st_n == DONE;
      if (issue) begin
        A_BIST_MEN <= 1'b1;
        A_BIST_WEN <= wr;
        A_BIST_REN <= !wr;
        A_BIST_ADDR <= addr;
        A_BIST_DIN <= wr ? data : '0;
        exp_d <= data;
        op_elem <= elem;
        fin <= last;
        slot <= !last_slot;
        addr <= addr_n;
        elem <= elem_end ? elem_n : elem;
        bg <= (elem_end && elem == LAST_ELEM) ? !bg : bg;
      end else begin
        {A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN} <= '0;
        {bg, elem, addr, slot, fin, exp_d, op_elem} <= '0;
      end
    end
  end
  assign A_BIST_BM = {P_DATA_WIDTH{A_BIST_EN}};
  rm_bist_cmp #(.AW(P_ADDR_WIDTH), .DW(P_DATA_WIDTH)) u_cmp (
    .clk       (BIST_CLK),
    .rst_n     (BIST_RESET_N),
    .clr       (go || stop),
    .rd        (A_BIST_MEN && A_BIST_REN),
    .addr      (A_BIST_ADDR),
    .exp_data  (exp_d),
    .elem      (op_elem),
    .dout      (A_DOUT),
    .fail      (BIST_FAIL),
    .fail_addr (BIST_FAIL_ADDR),
    .fail_xor  (BIST_FAIL_XOR),
    .fail_elem (BIST_FAIL_ELEM)
  );
endmodule

// File: tb/tb_rm_ihpsg13_bist_march_ctrl.sv
// tb_rm_ihpsg13_bist_march_ctrl: BIST controller against a faulty-SRAM model and a March C- reference
module tb_rm_ihpsg13_bist_march_ctrl;
  localparam logic [63:0] BG1 = {32{2'b01}};
  logic        clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [63:0] dout = '0;
  logic        en, men, wen, ren, busy, done, fail;
  logic [7:0]  addr, f_addr;
  logic [63:0] din, bm, f_xor;
  logic [2:0]  f_elem;
  int          n_chk = 0, n_err = 0;
  logic [63:0] mem [256];
  bit          st_on = 0, cpl_on = 0;
  logic [7:0]  st_a, cpl_a, cpl_v;
  int          st_b, cpl_b;
  logic [73:0] act_ops[$], exp_ops[$];
  int          busy_cnt, bm_bad;
  bit          e_fail;
  logic [7:0]  e_addr;
  logic [63:0] e_xor;
  int          e_elem;
  // op codes: 0 = w(B), 1 = w(~B), 2 = r(B), 3 = r(~B), -1 = none
  int tbl [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};

  rm_ihpsg13_bist_march_ctrl dut (
    .BIST_CLK(clk), .BIST_RESET_N(rst_n), .BIST_START(start), .BIST_ABORT(abort), .A_DOUT(dout),
    .A_BIST_EN(en), .A_BIST_MEN(men), .A_BIST_WEN(wen), .A_BIST_REN(ren), .A_BIST_ADDR(addr),
    .A_BIST_DIN(din), .A_BIST_BM(bm), .BIST_BUSY(busy), .BIST_DONE(done), .BIST_FAIL(fail),
    .BIST_FAIL_ADDR(f_addr), .BIST_FAIL_XOR(f_xor), .BIST_FAIL_ELEM(f_elem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (men && wen) begin
      mem[addr] <= din;
      if (cpl_on && addr == cpl_a) mem[cpl_v] <= mem[cpl_v] ^ (64'd1 << cpl_b);
    end
    if (men && ren) dout <= mem[addr] | ((st_on && addr == st_a) ? 64'd1 << st_b : 64'd0);
  end

  always @(negedge clk) begin
    if (men) act_ops.push_back({wen, ren, addr, wen ? din : 64'd0});
    if (busy) busy_cnt++;
    if (en != busy || bm != {64{en}}) bm_bad++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    logic [63:0] m [256];
    logic [63:0] b, d, v;
    int a, code;
    exp_ops.delete();
    e_fail = 0; e_addr = 0; e_xor = 0; e_elem = 0;
    for (int i = 0; i < 256; i++) m[i] = '0;
    for (int g = 0; g < 2; g++) begin
      b = g ? BG1 : 64'd0;
      for (int e = 0; e < 6; e++)
        for (int i = 0; i < 256; i++) begin
          a = e >= 3 ? 255 - i : i;
          for (int s = 0; s < 2; s++) begin
            code = tbl[e][s];
            if (code < 0) continue;
            d = (code % 2) ? ~b : b;
            if (code < 2) begin
              m[a] = d;
              if (cpl_on && a == int'(cpl_a)) m[cpl_v] = m[cpl_v] ^ (64'd1 << cpl_b);
              exp_ops.push_back({1'b1, 1'b0, 8'(a), d});
            end else begin
              v = m[a] | ((st_on && a == int'(st_a)) ? 64'd1 << st_b : 64'd0);
              exp_ops.push_back({1'b0, 1'b1, 8'(a), 64'd0});
              if (v != d && !e_fail) begin
                e_fail = 1; e_addr = 8'(a); e_xor = v ^ d; e_elem = e;
              end
            end
          end
        end
    end
  endtask

  task automatic arm();
    act_ops.delete();
    busy_cnt = 0;
    bm_bad = 0;
  endtask

  task automatic launch();
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 arm();
  endtask

  task automatic finish_run(input string tag);
    int n = 0, fd = -1;
    while (!done && n < 6000) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_cycles"}, n, 5121);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 5121);
    check({tag, "_men_pulses"}, act_ops.size(), 5120);
    for (int i = 0; i < act_ops.size() && i < exp_ops.size(); i++)
      if (fd < 0 && act_ops[i] !== exp_ops[i]) fd = i;
    if (fd < 0 && act_ops.size() != exp_ops.size()) fd = act_ops.size();
    check({tag, "_op_first_diff"}, fd, -1);
    check({tag, "_fail"}, fail, e_fail);
    check({tag, "_fail_addr"}, f_addr, e_addr);
    check({tag, "_fail_xor"}, f_xor, e_xor);
    check({tag, "_fail_elem"}, f_elem, e_elem);
    check({tag, "_bm_en"}, bm_bad, 0);
    check({tag, "_idle_pins"}, |{men, wen, ren, addr, din, en, bm}, 0);
  endtask

  task automatic good_run(input string tag);
    st_on = 0; cpl_on = 0;
    build_model();
    launch();
    start = 0;
    finish_run(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 check("rst_outs", |{en, men, wen, ren, addr, din, bm, busy, done, fail, f_addr, f_xor, f_elem}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 check("idle_no_start", busy, 0);

    good_run("good");

    st_on = 1; st_a = 8'h3C; st_b = 5;
    build_model();
    launch();
    start = 0;
    finish_run("stuck");
    check("stuck_addr_3c", f_addr, 8'h3C);
    check("stuck_xor_20", f_xor, 64'h20);
    check("stuck_elem_1", f_elem, 1);

    st_on = 0; cpl_on = 1; cpl_a = 8'h10; cpl_v = 8'h11; cpl_b = 0;
    build_model();
    launch();
    start = 0;
    finish_run("coupling");
    check("coupling_addr_11", f_addr, 8'h11);

    for (int r = 0; r < 3; r++) begin
      st_on = $urandom_range(1);
      cpl_on = !st_on;
      st_a = 8'($urandom_range(255)); st_b = $urandom_range(63);
      cpl_a = 8'($urandom_range(255)); cpl_v = cpl_a + 8'($urandom_range(254) + 1); cpl_b = $urandom_range(63);
      build_model();
      launch();
      start = 0;
      finish_run($sformatf("rand%0d", r));
    end

    cpl_on = 0; st_on = 1; st_a = 8'h3C; st_b = 5;
    launch();
    start = 0;
    repeat (700) @(posedge clk);
    #1 check("abort_pre_fail", fail, 1);
    @(negedge clk) begin abort = 1; start = 1; end
    @(posedge clk);
    #1 check("abort_busy", busy, 0);
    check("abort_pins", |{men, wen, ren, addr, din, en, bm}, 0);
    check("abort_done", done, 0);
    check("abort_fail", fail, 0);
    @(posedge clk);
    #1 check("abort_wins_idle", busy, 0);
    @(negedge clk) begin abort = 0; start = 0; end

    st_on = 0;
    launch();
    start = 0;
    repeat (3000) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1 check("midrst_outs", |{en, men, wen, ren, addr, din, bm, busy, done, fail, f_addr, f_xor, f_elem}, 0);
    @(negedge clk) rst_n = 1;
    good_run("after_rst");

    st_on = 1; st_a = 8'h3C; st_b = 5;
    build_model();
    launch();
    finish_run("b2b_run1");
    arm();
    @(posedge clk);
    #1 check("b2b_restart_busy", busy, 1);
    check("b2b_fail_cleared", fail, 0);
    check("b2b_done_cleared", done, 0);
    start = 0;
    finish_run("b2b_run2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
